// File: rtl/full_logic_pkg.sv
// Shared definitions for the full_logic destination-FIFO drain path.
package full_logic_pkg;

    localparam int   DATA_WIDTH = 6;
    localparam logic SRC_D0     = 1'b0;
    localparam logic SRC_D1     = 1'b1;
    // Bit of each word that encodes the destination it was routed to.
    localparam int   DEST_BIT   = 4;

    // Occupancy of the 2-entry output buffer; the encoding doubles as the count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic logic [1:0] buf_occ(input buf_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/full_logic_drain_skid_buf.sv
// drain_skid_buf: 2-entry synchronous buffer with registered head, used to
// absorb the one-cycle FIFO read latency in full_logic_drain.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   BUF_EMPTY | no entries; head_q holds the last word out
//   BUF_ONE   | head_q valid, tail_q unused
//   BUF_FULL  | head_q and tail_q valid, tail_q is the newer
module drain_skid_buf
    import full_logic_pkg::*;
#(
    parameter int width = DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [width-1:0] din_i,
    input  logic             pop_i,
    output logic [1:0]       occ_o,
    output logic [width-1:0] head_o
);

    buf_state_e       state_q, state_d;
    logic [width-1:0] head_q, head_d;
    logic [width-1:0] tail_q, tail_d;

    // Next-state and data movement; push and pop in one edge keep occupancy
    // and preserve order (the newest word lands behind the existing one).
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push_i) begin
                    head_d  = din_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push_i && pop_i) begin
                    head_d = din_i;
                end else if (push_i) begin
                    tail_d  = din_i;
                    state_d = BUF_FULL;
                end else if (pop_i) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                // A push without a pop here would overflow; the issue rule in
                // the top prevents it, so the word is simply not stored.
                if (pop_i) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = din_i;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

    // State and storage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign occ_o  = buf_occ(state_q);
    assign head_o = head_q;

endmodule

// File: rtl/full_logic_drain.sv
// full_logic_drain: round-robin reader for the two full_logic destination
// FIFOs, delivering a single valid/ready stream tagged with the source.
// Optional routing check enabled by defining FULL_LOGIC_DRAIN_CHECK_EN.
module full_logic_drain
    import full_logic_pkg::*;
#(
    parameter int data_width  = DATA_WIDTH,
    parameter int count_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   drain_en,
    input  logic                   empty_fifo_D0,
    input  logic                   empty_fifo_D1,
    input  logic [data_width-1:0]  data_out_D0,
    input  logic [data_width-1:0]  data_out_D1,
    output logic                   D0_pop,
    output logic                   D1_pop,
    input  logic                   sink_ready,
    output logic [data_width-1:0]  data_out,
    output logic                   data_valid,
    output logic                   src_id,
    output logic [count_width-1:0] count_D0,
    output logic [count_width-1:0] count_D1,
    output logic                   misroute
);

    localparam logic [count_width-1:0] CNT_ONE = 1;

    logic                   pend_valid_q, pend_valid_d;
    logic                   pend_src_q, pend_src_d;
    logic                   last_src_q, last_src_d;
    logic [count_width-1:0] count_D0_q, count_D0_d;
    logic [count_width-1:0] count_D1_q, count_D1_d;

    logic [1:0]             occ;
    logic [data_width:0]    head;
    logic [data_width-1:0]  cap_word;
    logic                   deq;
    logic [2:0]             level;
    logic                   pop_ok;

    assign data_valid = (occ != 2'd0);
    assign data_out   = head[data_width-1:0];
    assign src_id     = head[data_width];
    assign deq        = data_valid && sink_ready;

    // Words already committed (buffered plus in flight) minus the one leaving
    // this cycle must stay below 2 for a new pop to have a guaranteed slot.
    assign level  = {1'b0, occ} + {2'b00, pend_valid_q};
    assign pop_ok = drain_en && reset && (level < (3'd2 + {2'b00, deq}));

    // Round-robin pop selection: with both FIFOs ready, serve the one not
    // served last.
    always_comb begin
        D0_pop = 1'b0;
        D1_pop = 1'b0;
        if (pop_ok) begin
            if (!empty_fifo_D0 && !empty_fifo_D1) begin
                D0_pop = (last_src_q == SRC_D1);
                D1_pop = (last_src_q == SRC_D0);
            end else if (!empty_fifo_D0) begin
                D0_pop = 1'b1;
            end else if (!empty_fifo_D1) begin
                D1_pop = 1'b1;
            end
        end
    end

    // Word presented by the FIFO popped in the previous cycle.
    assign cap_word = (pend_src_q == SRC_D1) ? data_out_D1 : data_out_D0;

    // In-flight tracking, arbitration history and saturating delivery counters.
    always_comb begin
        pend_valid_d = D0_pop || D1_pop;
        pend_src_d   = D1_pop ? SRC_D1 : SRC_D0;
        last_src_d   = last_src_q;
        if (D0_pop) last_src_d = SRC_D0;
        if (D1_pop) last_src_d = SRC_D1;
        count_D0_d = count_D0_q;
        count_D1_d = count_D1_q;
        if (deq && (src_id == SRC_D0) && (count_D0_q != '1)) begin
            count_D0_d = count_D0_q + CNT_ONE;
        end
        if (deq && (src_id == SRC_D1) && (count_D1_q != '1)) begin
            count_D1_d = count_D1_q + CNT_ONE;
        end
    end

    // Control registers; reset drops any in-flight word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_valid_q <= 1'b0;
            pend_src_q   <= SRC_D0;
            last_src_q   <= SRC_D1;
            count_D0_q   <= '0;
            count_D1_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_src_q   <= pend_src_d;
            last_src_q   <= last_src_d;
            count_D0_q   <= count_D0_d;
            count_D1_q   <= count_D1_d;
        end
    end

    assign count_D0 = count_D0_q;
    assign count_D1 = count_D1_q;

    drain_skid_buf #(
        .width (data_width + 1)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .push_i (pend_valid_q),
        .din_i  ({pend_src_q, cap_word}),
        .pop_i  (deq),
        .occ_o  (occ),
        .head_o (head)
    );

`ifdef FULL_LOGIC_DRAIN_CHECK_EN
    logic       misroute_q, misroute_d;
    logic [7:0] mis_cnt_q, mis_cnt_d;
    logic       mis_hit;

    assign mis_hit = pend_valid_q && (cap_word[DEST_BIT] != pend_src_q);

    // Sticky misroute flag and saturating mismatch count, kept for debug.
    always_comb begin
        misroute_d = misroute_q || mis_hit;
        mis_cnt_d  = mis_cnt_q;
        if (mis_hit && (mis_cnt_q != 8'hFF)) begin
            mis_cnt_d = mis_cnt_q + 8'd1;
        end
    end

    // Check registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            misroute_q <= 1'b0;
            mis_cnt_q  <= '0;
        end else begin
            misroute_q <= misroute_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    assign misroute = misroute_q;
`else
    assign misroute = 1'b0;
`endif

endmodule

// File: tb/tb_full_logic_drain.sv
// Directed bench for full_logic_drain with a simple two-FIFO source model.
module tb_full_logic_drain;

    logic       clk = 1'b0;
    logic       reset;
    logic       drain_en;
    logic       sink_ready;
    logic       empty_fifo_D0, empty_fifo_D1;
    logic [5:0] data_out_D0 = '0;
    logic [5:0] data_out_D1 = '0;
    logic       D0_pop, D1_pop;
    logic [5:0] data_out;
    logic       data_valid, src_id;
    logic [7:0] count_D0, count_D1;
    logic       misroute;

    int n_chk  = 0;
    int n_pass = 0;
    int ovf_cnt = 0;

    logic [5:0] mem0 [16];
    logic [5:0] mem1 [16];
    int rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;

    logic exp_mis;

    always #5 clk = ~clk;

    full_logic_drain dut (
        .clk           (clk),
        .reset         (reset),
        .drain_en      (drain_en),
        .empty_fifo_D0 (empty_fifo_D0),
        .empty_fifo_D1 (empty_fifo_D1),
        .data_out_D0   (data_out_D0),
        .data_out_D1   (data_out_D1),
        .D0_pop        (D0_pop),
        .D1_pop        (D1_pop),
        .sink_ready    (sink_ready),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .src_id        (src_id),
        .count_D0      (count_D0),
        .count_D1      (count_D1),
        .misroute      (misroute)
    );

    assign empty_fifo_D0 = (rd0 == wr0);
    assign empty_fifo_D1 = (rd1 == wr1);

    // FIFO model: a pop at an edge presents the word during the next cycle.
    always @(posedge clk) begin
        if (D0_pop) begin
            data_out_D0 <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (D1_pop) begin
            data_out_D1 <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    // Buffer overflow watch: push into a full buffer without a pop.
    always @(negedge clk) begin
        if (dut.u_buf.occ_o == 2'd2 && dut.pend_valid_q && !dut.deq) ovf_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [5:0] w);
        mem0[wr0] = w;
        wr0++;
    endtask

    task automatic push1(input logic [5:0] w);
        mem1[wr1] = w;
        wr1++;
    endtask

    initial begin
`ifdef FULL_LOGIC_DRAIN_CHECK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        reset = 1'b0; drain_en = 1'b1; sink_ready = 1'b1;
        push0(6'h01); push0(6'h02); push0(6'h03);
        push1(6'h11); push1(6'h12); push1(6'h13);
        tick;

        // Reset hold with both FIFOs non-empty.
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rst_d0pop", D0_pop, 0);
            chk("rst_d1pop", D1_pop, 0);
            chk("rst_valid", data_valid, 0);
            chk("rst_data", data_out, 0);
            chk("rst_src", src_id, 0);
            chk("rst_cnt0", count_D0, 0);
            chk("rst_cnt1", count_D1, 0);
            chk("rst_mis", misroute, 0);
            tick;
        end

        // Round-robin with sink always ready.
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [5:0] w;
            int k;
            #1;
            chk("rr_d0pop", D0_pop, (i < 6) && (i % 2 == 0));
            chk("rr_d1pop", D1_pop, (i < 6) && (i % 2 == 1));
            chk("rr_valid", data_valid, i >= 2);
            if (i >= 2) begin
                k = i - 2;
                w = (k % 2 == 0) ? 6'(8'h01 + k / 2) : 6'(8'h11 + k / 2);
                chk("rr_data", data_out, w);
                chk("rr_src", src_id, k % 2);
            end
            tick;
        end
        chk("rr_valid_end", data_valid, 0);
        chk("rr_cnt0", count_D0, 3);
        chk("rr_cnt1", count_D1, 3);

        // Backpressure on a single D1 source.
        sink_ready = 1'b0;
        push1(6'h14); push1(6'h15); push1(6'h16); push1(6'h17);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("bp_d1pop", D1_pop, i < 2);
            chk("bp_d0pop", D0_pop, 0);
            chk("bp_valid", data_valid, i >= 2);
            if (i >= 2) begin
                chk("bp_hold_data", data_out, 6'h14);
                chk("bp_hold_src", src_id, 1);
            end
            tick;
        end
        sink_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rel_d1pop", D1_pop, i < 2);
            chk("bp_rel_valid", data_valid, i < 4);
            if (i < 4) chk("bp_rel_data", data_out, 6'(8'h14 + i));
            tick;
        end
        chk("bp_cnt0", count_D0, 3);
        chk("bp_cnt1", count_D1, 7);

        // Single source D0, back-to-back pops.
        push0(6'b000101); push0(6'b000100);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ss_d0pop", D0_pop, i < 2);
            chk("ss_d1pop", D1_pop, 0);
            chk("ss_valid", data_valid, (i == 2) || (i == 3));
            if (i == 2) chk("ss_data0", data_out, 6'b000101);
            if (i == 3) chk("ss_data1", data_out, 6'b000100);
            if (i == 2 || i == 3) chk("ss_src", src_id, 0);
            tick;
        end
        chk("ss_cnt0", count_D0, 5);

        // Reset in the cycle after a pop discards the in-flight word.
        push0(6'h07);
        #1;
        chk("mf_pop", D0_pop, 1);
        tick;
        reset = 1'b0;
        #1;
        chk("mf_rst_nopop", D0_pop, 0);
        tick;
        chk("mf_valid", data_valid, 0);
        chk("mf_occ", dut.u_buf.occ_o, 0);
        chk("mf_data", data_out, 0);
        chk("mf_cnt0", count_D0, 0);
        chk("mf_cnt1", count_D1, 0);

        // drain_en low blocks pops; last_src is back at its reset value.
        reset = 1'b1; drain_en = 1'b0;
        push0(6'h08); push1(6'h18);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("de_d0pop", D0_pop, 0);
            chk("de_d1pop", D1_pop, 0);
            chk("de_valid", data_valid, 0);
            tick;
        end
        drain_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("de_d0pop_on", D0_pop, i == 0);
            chk("de_d1pop_on", D1_pop, i == 1);
            chk("de_valid_on", data_valid, (i == 2) || (i == 3));
            if (i == 2) begin
                chk("de_data0", data_out, 6'h08);
                chk("de_src0", src_id, 0);
            end
            if (i == 3) begin
                chk("de_data1", data_out, 6'h18);
                chk("de_src1", src_id, 1);
            end
            tick;
        end
        chk("de_cnt0", count_D0, 1);
        chk("de_cnt1", count_D1, 1);
        chk("de_mis", misroute, 0);

        // Misrouted word from D0 (destination bit set).
        push0(6'b010100);
        #1;
        chk("mr_pop", D0_pop, 1);
        tick;
        chk("mr_mis_before", misroute, 0);
        tick;
        chk("mr_data", data_out, 6'b010100);
        chk("mr_src", src_id, 0);
        chk("mr_mis_rise", misroute, exp_mis);
        tick;
        chk("mr_mis_hold1", misroute, exp_mis);
        tick;
        chk("mr_mis_hold2", misroute, exp_mis);
        chk("mr_cnt0", count_D0, 2);

        chk("no_overflow", ovf_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
